// File: rtl/lv2_bus_responder.sv
// L2-side responder for the lv1<->lv2 request bus: services one L1 line fill or writeback
// at a time through a single main-memory transaction, then answers on the shared tri-state bus.
module lv2_bus_responder #(
  parameter int DATA_WID    = 32,
  parameter int ADDR_WID    = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  inout  wire  [ADDR_WID-1:0] addr_bus_lv1_lv2,
  inout  wire  [DATA_WID-1:0] data_bus_lv1_lv2,
  inout  wire                 data_in_bus_lv1_lv2,
  input  logic                lv2_rd,
  input  logic                lv2_wr,
  output logic                lv2_wr_done,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [ADDR_WID-1:0] mem_addr,
  output logic [DATA_WID-1:0] mem_wdata,
  input  logic [DATA_WID-1:0] mem_rdata,
  input  logic                mem_ack,
  output logic                busy,
  output logic                err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  // Abort decision is made on the edge that would bring the count up to TIMEOUT_CYC.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    IDLE,
    MEM_RD,
    RESP_RD,
    MEM_WR,
    WR_DONE,
    DRAIN
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    tmo_cnt;
  logic [DATA_WID-1:0] rd_data;
  logic                drive_en;
  logic [CNT_W-1:0]    tmo_next;

  assign data_bus_lv1_lv2    = drive_en ? rd_data : {DATA_WID{1'bz}};
  assign data_in_bus_lv1_lv2 = drive_en ? 1'b1 : 1'bz;
  assign tmo_next            = (tmo_cnt == CNT_MAX) ? tmo_cnt : tmo_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      rd_data     <= '0;
      drive_en    <= 1'b0;
      lv2_wr_done <= 1'b0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Writeback wins over a simultaneous fill; the fill is picked up after WR_DONE.
          if (lv2_wr) begin
            mem_addr  <= addr_bus_lv1_lv2;
            mem_wdata <= data_bus_lv1_lv2;
            mem_wr    <= 1'b1;
            tmo_cnt   <= '0;
            busy      <= 1'b1;
            state     <= MEM_WR;
          end else if (lv2_rd) begin
            mem_addr <= addr_bus_lv1_lv2;
            mem_rd   <= 1'b1;
            tmo_cnt  <= '0;
            busy     <= 1'b1;
            state    <= MEM_RD;
          end
        end

        MEM_RD: begin
          if (mem_ack) begin
            mem_rd <= 1'b0;
            if (lv2_rd) begin
              rd_data  <= mem_rdata;
              drive_en <= 1'b1;
              state    <= RESP_RD;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (!lv2_rd) begin
            tmo_cnt <= '0;
            state   <= DRAIN;
          end else if (tmo_cnt == CNT_LAST) begin
            mem_rd      <= 1'b0;
            err_timeout <= 1'b1;
            tmo_cnt     <= tmo_next;
            rd_data     <= '1;
            drive_en    <= 1'b1;
            state       <= RESP_RD;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end

        RESP_RD: begin
          if (!lv2_rd) begin
            drive_en <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end

        MEM_WR: begin
          // A writeback is never cancelled; lv2_wr is not looked at until WR_DONE.
          if (mem_ack || tmo_cnt == CNT_LAST) begin
            if (!mem_ack) begin
              err_timeout <= 1'b1;
            end
            mem_wr      <= 1'b0;
            lv2_wr_done <= 1'b1;
            tmo_cnt     <= mem_ack ? tmo_cnt : tmo_next;
            state       <= WR_DONE;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end

        WR_DONE: begin
          if (!lv2_wr) begin
            lv2_wr_done <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end

        DRAIN: begin
          // Abandoned fill: keep the memory request up until it completes, then drop the data.
          if (mem_ack || tmo_cnt == CNT_LAST) begin
            if (!mem_ack) begin
              err_timeout <= 1'b1;
            end
            mem_rd  <= 1'b0;
            busy    <= 1'b0;
            tmo_cnt <= mem_ack ? tmo_cnt : tmo_next;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end

        default: begin
          drive_en    <= 1'b0;
          lv2_wr_done <= 1'b0;
          mem_rd      <= 1'b0;
          mem_wr      <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lv2_bus_responder.sv
// Scoreboard bench for lv2_bus_responder: stimulus queues expected bus/memory events,
// a monitor pops and compares them as the DUT produces them.
module tb_lv2_bus_responder;

  logic        clk;
  logic        rst;
  logic        lv2_rd;
  logic        lv2_wr;
  logic        lv2_wr_done;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        busy;
  logic        err_timeout;

  logic [31:0] addr_drv;
  logic [31:0] data_drv;
  logic        data_drv_en;

  wire  [31:0] addr_bus_lv1_lv2;
  wire  [31:0] data_bus_lv1_lv2;
  wire         data_in_bus_lv1_lv2;

  assign addr_bus_lv1_lv2 = addr_drv;
  assign data_bus_lv1_lv2 = data_drv_en ? data_drv : 32'hzzzz_zzzz;

  typedef enum logic [1:0] {EV_MEMRD, EV_MEMWR, EV_RDRESP, EV_WRDONE} ev_kind_t;
  typedef struct packed {
    ev_kind_t    kind;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t         exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          ack_delay = 1;
  bit          ack_en    = 1'b1;
  logic [31:0] rdata_v   = 32'h0;
  bit          bus_forbid = 1'b0;

  localparam int W_DIN  = 0;
  localparam int W_DONE = 1;
  localparam int W_IDLE = 2;

  lv2_bus_responder #(
    .DATA_WID   (32),
    .ADDR_WID   (32),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .addr_bus_lv1_lv2   (addr_bus_lv1_lv2),
    .data_bus_lv1_lv2   (data_bus_lv1_lv2),
    .data_in_bus_lv1_lv2(data_in_bus_lv1_lv2),
    .lv2_rd             (lv2_rd),
    .lv2_wr             (lv2_wr),
    .lv2_wr_done        (lv2_wr_done),
    .mem_rd             (mem_rd),
    .mem_wr             (mem_wr),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_rdata          (mem_rdata),
    .mem_ack            (mem_ack),
    .busy               (busy),
    .err_timeout        (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
    end
  endtask

  task automatic expectEvent(input ev_kind_t kind, input logic [31:0] addr, input logic [31:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic drive_data);
    @(negedge clk);
    lv2_rd      = rd;
    lv2_wr      = wr;
    addr_drv    = addr;
    data_drv    = data;
    data_drv_en = drive_data;
  endtask

  function automatic logic condMet(input int which);
    case (which)
      W_DIN:   return data_in_bus_lv1_lv2 === 1'b1;
      W_DONE:  return lv2_wr_done === 1'b1;
      default: return busy === 1'b0;
    endcase
  endfunction

  task automatic waitFor(input int which, input string name, output int cyc);
    cyc = 0;
    while (!condMet(which) && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    if (!condMet(which)) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s: condition not reached after %0d cycles, required within 60", name, cyc);
    end
  endtask

  // Pop the oldest expected event and compare it with what the DUT just presented.
  task automatic scoreEvent(input ev_kind_t kind, input logic [31:0] addr, input logic [31:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL unexpected_event: got kind %0d, required no event", kind);
    end else begin
      e = exp_q.pop_front();
      checkOutput("event_kind", 32'(kind), 32'(e.kind));
      if (kind == e.kind) begin
        if (kind == EV_MEMRD || kind == EV_MEMWR) checkOutput("event_addr", addr, e.addr);
        if (kind == EV_MEMWR || kind == EV_RDRESP) checkOutput("event_data", data, e.data);
      end
    end
  endtask

  // Memory model: acknowledges a pending request ack_delay cycles after it rises.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst || mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (mem_rd || mem_wr) begin
        wait_cnt++;
        if (ack_en && wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata_v;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: turns rising edges of DUT outputs into scoreboard events.
  initial begin
    logic prev_rd, prev_wr, prev_done, prev_din;
    prev_rd = 1'b0; prev_wr = 1'b0; prev_done = 1'b0; prev_din = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_wr && !prev_wr) scoreEvent(EV_MEMWR, mem_addr, mem_wdata);
        if (lv2_wr_done && !prev_done) scoreEvent(EV_WRDONE, 32'h0, 32'h0);
        if (mem_rd && !prev_rd) scoreEvent(EV_MEMRD, mem_addr, 32'h0);
        if (data_in_bus_lv1_lv2 === 1'b1 && !prev_din) scoreEvent(EV_RDRESP, 32'h0, data_bus_lv1_lv2);
        if (bus_forbid) checkOutput("bus_not_driven", 32'(data_in_bus_lv1_lv2 === 1'b1), 32'd0);
      end
      prev_rd   = mem_rd;
      prev_wr   = mem_wr;
      prev_done = lv2_wr_done;
      prev_din  = (data_in_bus_lv1_lv2 === 1'b1);
    end
  end

  task automatic doRead(input logic [31:0] addr, input logic [31:0] rdata, input int delay);
    int cyc;
    ack_delay = delay;
    rdata_v   = rdata;
    expectEvent(EV_MEMRD, addr, 32'h0);
    expectEvent(EV_RDRESP, 32'h0, rdata);
    applyStimulus(1'b1, 1'b0, addr, 32'h0, 1'b0);
    waitFor(W_DIN, "rd_response", cyc);
    checkOutput("rd_latency", cyc, delay + 1);
    checkOutput("rd_busy", 32'(busy), 32'd1);
    repeat (2) begin
      @(negedge clk);
      checkOutput("rd_hold_data", data_bus_lv1_lv2, rdata);
      checkOutput("rd_hold_valid", 32'(data_in_bus_lv1_lv2 === 1'b1), 32'd1);
    end
    applyStimulus(1'b0, 1'b0, addr, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("rd_release", 32'(data_in_bus_lv1_lv2 === 1'b1), 32'd0);
    checkOutput("rd_idle", 32'(busy), 32'd0);
  endtask

  task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input int delay);
    int cyc;
    ack_delay = delay;
    expectEvent(EV_MEMWR, addr, data);
    expectEvent(EV_WRDONE, 32'h0, 32'h0);
    bus_forbid = 1'b1;
    applyStimulus(1'b0, 1'b1, addr, data, 1'b1);
    waitFor(W_DONE, "wr_done", cyc);
    checkOutput("wr_latency", cyc, delay + 1);
    repeat (2) begin
      @(negedge clk);
      checkOutput("wr_done_hold", 32'(lv2_wr_done), 32'd1);
    end
    applyStimulus(1'b0, 1'b0, addr, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("wr_done_clear", 32'(lv2_wr_done), 32'd0);
    checkOutput("wr_idle", 32'(busy), 32'd0);
    bus_forbid = 1'b0;
  endtask

  initial begin
    int cyc;
    int n_rd_high;
    rst = 1'b1;
    lv2_rd = 1'b0;
    lv2_wr = 1'b0;
    addr_drv = 32'h0;
    data_drv = 32'h0;
    data_drv_en = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_mem_rd", 32'(mem_rd), 32'd0);
    checkOutput("rst_mem_wr", 32'(mem_wr), 32'd0);
    checkOutput("rst_wr_done", 32'(lv2_wr_done), 32'd0);
    checkOutput("rst_err", 32'(err_timeout), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_bus", 32'(data_in_bus_lv1_lv2 === 1'b1), 32'd0);
    rst = 1'b0;

    // Plain line fill, then plain writeback with minimum memory latency
    doRead(32'h0000_1040, 32'hA5A5_1234, 3);
    doWrite(32'h8000_0020, 32'hCAFE_F00D, 1);

    // Fill and writeback requested together: writeback retires first
    ack_delay = 2;
    rdata_v   = 32'h1357_9BDF;
    expectEvent(EV_MEMWR, 32'h8000_0100, 32'h1111_2222);
    expectEvent(EV_WRDONE, 32'h0, 32'h0);
    expectEvent(EV_MEMRD, 32'h0000_2040, 32'h0);
    expectEvent(EV_RDRESP, 32'h0, 32'h1357_9BDF);
    bus_forbid = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'h8000_0100, 32'h1111_2222, 1'b1);
    waitFor(W_DONE, "both_wr_done", cyc);
    checkOutput("both_no_mem_rd_yet", 32'(mem_rd), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0000_2040, 32'h0, 1'b0);
    bus_forbid = 1'b0;
    waitFor(W_DIN, "both_rd_response", cyc);
    checkOutput("both_rd_data", data_bus_lv1_lv2, 32'h1357_9BDF);
    applyStimulus(1'b0, 1'b0, 32'h0000_2040, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("both_idle", 32'(busy), 32'd0);

    // Memory never answers a fill: abort after 8 cycles with all-ones data
    ack_en = 1'b0;
    expectEvent(EV_MEMRD, 32'h0000_2000, 32'h0);
    expectEvent(EV_RDRESP, 32'h0, 32'hFFFF_FFFF);
    checkOutput("tmo_err_before", 32'(err_timeout), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0000_2000, 32'h0, 1'b0);
    n_rd_high = 0;
    cyc = 0;
    while (data_in_bus_lv1_lv2 !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mem_rd) n_rd_high++;
    end
    checkOutput("tmo_mem_rd_cycles", n_rd_high, 32'd8);
    checkOutput("tmo_err_set", 32'(err_timeout), 32'd1);
    checkOutput("tmo_data", data_bus_lv1_lv2, 32'hFFFF_FFFF);
    checkOutput("tmo_mem_rd_low", 32'(mem_rd), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0000_2000, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("tmo_err_sticky", 32'(err_timeout), 32'd1);
    checkOutput("tmo_idle", 32'(busy), 32'd0);
    ack_en = 1'b1;

    // Fill withdrawn before memory answers: drain the ack, never touch the bus
    ack_delay = 4;
    rdata_v   = 32'hDEAD_BEEF;
    expectEvent(EV_MEMRD, 32'h0000_3000, 32'h0);
    bus_forbid = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0000_3000, 32'h0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0000_3000, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("drain_busy", 32'(busy), 32'd1);
    checkOutput("drain_mem_rd_held", 32'(mem_rd), 32'd1);
    waitFor(W_IDLE, "drain_idle", cyc);
    checkOutput("drain_mem_rd_low", 32'(mem_rd), 32'd0);
    checkOutput("drain_err_kept", 32'(err_timeout), 32'd1);
    repeat (2) @(negedge clk);
    bus_forbid = 1'b0;

    // Asynchronous reset in the middle of a writeback
    ack_delay = 6;
    expectEvent(EV_MEMWR, 32'h4000_0040, 32'h0BAD_CAFE);
    applyStimulus(1'b0, 1'b1, 32'h4000_0040, 32'h0BAD_CAFE, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("rst_pre_mem_wr", 32'(mem_wr), 32'd1);
    #2;
    rst = 1'b1;
    lv2_wr = 1'b0;
    data_drv_en = 1'b0;
    #1;
    checkOutput("arst_mem_wr", 32'(mem_wr), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_bus", 32'(data_in_bus_lv1_lv2 === 1'b1), 32'd0);
    checkOutput("arst_err", 32'(err_timeout), 32'd0);
    checkOutput("arst_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    doRead(32'h0000_5000, 32'h600D_F00D, 2);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
